// File: rtl/edac_4bit_encoder.sv
// EDAC write-path encoder: latches a 16-bit word and appends a CRC-4
// computed one nibble per cycle (MSB nibble first), no lookup table.
module edac_4bit_encoder #(
  parameter logic [3:0] POLY = 4'h3,
  parameter logic [3:0] INIT = 4'h0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        en,
  input  logic        WRITE,
  input  logic [15:0] DIN,
  output logic [15:0] DOUT,
  output logic [7:0]  CRC,
  output logic        valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] data_q;
  logic [3:0]  crc_q;
  logic [3:0]  crc_nx;
  logic [3:0]  nib;
  logic [1:0]  cnt;
  logic        req;
  logic        load;
  logic        step;

  assign req = en & WRITE;

  // Multiply by x^4 modulo the generator: four shift/XOR steps.
  function automatic logic [3:0] mul_x4(input logic [3:0] c);
    logic [3:0] r;
    r = c;
    for (int i = 0; i < 4; i++) begin
      if (r[3]) r = {r[2:0], 1'b0} ^ POLY;
      else      r = {r[2:0], 1'b0};
    end
    return r;
  endfunction

  // Select the nibble for this cycle, MSB nibble first.
  always_comb begin
    nib = data_q[15:12];
    unique case (cnt)
      2'd0: nib = data_q[15:12];
      2'd1: nib = data_q[11:8];
      2'd2: nib = data_q[7:4];
      2'd3: nib = data_q[3:0];
    endcase
    crc_nx = mul_x4(crc_q ^ nib);
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    valid    = 1'b0;
    busy     = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (req) begin
          state_nx = CALC;
          load     = 1'b1;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt == 2'd3) state_nx = DONE;
      end
      DONE: begin
        valid = 1'b1;
        if (req) begin
          state_nx = CALC;
          load     = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Data latch, CRC accumulator and result registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_q <= '0;
      crc_q  <= INIT;
      cnt    <= '0;
      DOUT   <= '0;
      CRC    <= '0;
    end else if (load) begin
      data_q <= DIN;
      crc_q  <= INIT;
      cnt    <= '0;
    end else if (step) begin
      crc_q <= crc_nx;
      cnt   <= cnt + 2'd1;
      if (cnt == 2'd3) begin
        DOUT <= data_q;
        CRC  <= {4'h0, crc_nx};
      end
    end
  end

endmodule

// File: tb/tb_edac_4bit_encoder.sv
// Directed bench for edac_4bit_encoder: vector table plus
// hand-written sequences for drop, hold and async-reset cases.
module tb_edac_4bit_encoder;

  logic        CLK;
  logic        RST;
  logic        en;
  logic        WRITE;
  logic [15:0] DIN;
  logic [15:0] DOUT;
  logic [7:0]  CRC;
  logic        valid;
  logic        busy;

  int errors;
  int checks;

  typedef struct {
    logic [15:0] din;
    logic [7:0]  crc;
  } vec_t;

  vec_t vecs[7];

  edac_4bit_encoder dut (
    .CLK  (CLK),
    .RST  (RST),
    .en   (en),
    .WRITE(WRITE),
    .DIN  (DIN),
    .DOUT (DOUT),
    .CRC  (CRC),
    .valid(valid),
    .busy (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // One request; checks busy/valid timing and the result.
  task automatic run_req(input logic [15:0] d, input logic [7:0] c,
                         input string name);
    en = 1'b1; WRITE = 1'b1; DIN = d;
    @(posedge CLK);
    #1;
    en = 1'b0; WRITE = 1'b0; DIN = ~d;
    @(negedge CLK);
    chk({name, " busy_e0"}, busy, 1);
    chk({name, " valid_e0"}, valid, 0);
    for (int i = 1; i < 4; i++) begin
      cyc();
      chk({name, " valid_early"}, valid, 0);
      chk({name, " busy_calc"}, busy, 1);
    end
    cyc();
    chk({name, " valid"}, valid, 1);
    chk({name, " busy_done"}, busy, 1);
    chk({name, " dout"}, DOUT, d);
    chk({name, " crc"}, CRC, c);
    cyc();
    chk({name, " valid_off"}, valid, 0);
    chk({name, " busy_off"}, busy, 0);
    chk({name, " crc_hold"}, CRC, c);
  endtask

  initial begin
    logic [15:0] dsave;
    logic [7:0]  csave;
    int          k;
    errors = 0;
    checks = 0;
    vecs[0] = '{16'h03F8, 8'h0F};
    vecs[1] = '{16'h0000, 8'h00};
    vecs[2] = '{16'hFFFF, 8'h03};
    vecs[3] = '{16'h0001, 8'h03};
    vecs[4] = '{16'h1234, 8'h0C};
    vecs[5] = '{16'h8000, 8'h03};
    vecs[6] = '{16'h0FF8, 8'h07};

    RST = 1'b1; en = 1'b0; WRITE = 1'b0; DIN = '0;
    repeat (2) @(negedge CLK);
    chk("rst dout", DOUT, 0);
    chk("rst crc", CRC, 0);
    chk("rst valid", valid, 0);
    chk("rst busy", busy, 0);
    RST = 1'b0;
    cyc();

    foreach (vecs[i]) begin
      run_req(vecs[i].din, vecs[i].crc, $sformatf("vec%0d", i));
      cyc();
    end

    // Request during CALC is dropped; held request taken after DONE.
    en = 1'b1; WRITE = 1'b1; DIN = 16'h03F8;
    @(posedge CLK);
    #1;
    DIN = 16'h0FF8;
    @(negedge CLK);
    repeat (3) cyc();
    cyc();
    chk("drop valid", valid, 1);
    chk("drop dout", DOUT, 16'h03F8);
    chk("drop crc", CRC, 8'h0F);
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (valid) begin
        k = i;
        break;
      end
    end
    en = 1'b0; WRITE = 1'b0;
    chk("hold period", k, 5);
    chk("hold dout", DOUT, 16'h0FF8);
    chk("hold crc", CRC, 8'h07);
    cyc();
    chk("hold release busy", busy, 0);
    chk("hold release valid", valid, 0);

    // Half requests do nothing.
    dsave = DOUT; csave = CRC;
    en = 1'b1; WRITE = 1'b0; DIN = 16'hAAAA;
    cyc();
    chk("en_only busy", busy, 0);
    chk("en_only valid", valid, 0);
    en = 1'b0; WRITE = 1'b1;
    cyc();
    chk("wr_only busy", busy, 0);
    chk("wr_only valid", valid, 0);
    WRITE = 1'b0;
    repeat (5) begin
      cyc();
      chk("half valid", valid, 0);
    end
    chk("half dout", DOUT, dsave);
    chk("half crc", CRC, csave);

    // Async reset mid-CALC.
    en = 1'b1; WRITE = 1'b1; DIN = 16'h1234;
    @(posedge CLK);
    #1;
    en = 1'b0; WRITE = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("arst dout", DOUT, 0);
    chk("arst crc", CRC, 0);
    chk("arst valid", valid, 0);
    chk("arst busy", busy, 0);
    @(negedge CLK);
    RST = 1'b0;
    k = 0;
    repeat (8) begin
      cyc();
      if (valid || busy) k++;
    end
    chk("arst no_valid", k, 0);
    run_req(16'h03F8, 8'h0F, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
